// File: rtl/soc_system_pio_sequencer_if.sv
// Bundle of the requester-side handshake and the PIO Avalon-MM register port
// seen by the PIO sequencer; the slave modport is the sequencer's view.
interface soc_system_pio_sequencer_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_wdata;
  logic [1:0]  req_ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [2:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  modport master (
    output req_valid,
    output req_write,
    output req_wdata,
    output pio_readdata,
    input  req_ack,
    input  rdata,
    input  busy,
    input  pio_address,
    input  pio_chipselect,
    input  pio_write_n,
    input  pio_writedata
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_wdata,
    input  pio_readdata,
    output req_ack,
    output rdata,
    output busy,
    output pio_address,
    output pio_chipselect,
    output pio_write_n,
    output pio_writedata
  );
endinterface

// File: rtl/soc_system_pio_sequencer.sv
// Round-robin arbiter that turns byte read/write requests from two requesters
// into direction-register / data-register sequences on the 8-bit PIO slave.
module soc_system_pio_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                       clk,
  input logic                       reset_n,
  soc_system_pio_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DIR     = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_XFER    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;

  localparam bit         HAS_SETTLE  = (SETTLE_CYCLES > 0);
  localparam logic [3:0] SETTLE_LOAD = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  logic [2:0] r_state;
  logic       r_grant;
  logic       r_last;
  logic       r_write;
  logic [7:0] r_byte;
  logic       r_dir_valid;
  logic       r_dir_out;
  logic [3:0] r_settle_cnt;
  logic [7:0] r_rdata;

  logic       w_grant;
  logic       w_sel_write;
  logic [7:0] w_sel_byte;
  logic       w_dir_hit;
  logic [7:0] w_req_byte [2];

  logic       w_cs;
  logic       w_write_n;
  logic [2:0] w_addr;
  logic [31:0] w_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_req_byte[gi]  = bus.req_wdata[8*gi +: 8];
      assign bus.req_ack[gi] = (r_state == S_ACK) && (r_grant == 1'(gi));
    end
  endgenerate

  // On a tie the requester that was not granted last wins.
  always_comb begin
    w_grant = 1'b0;
    if (&bus.req_valid) begin
      w_grant = ~r_last;
    end else if (bus.req_valid[1]) begin
      w_grant = 1'b1;
    end
  end

  assign w_sel_write = bus.req_write[w_grant];
  assign w_sel_byte  = w_req_byte[w_grant];
  assign w_dir_hit   = r_dir_valid && (r_dir_out == w_sel_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last       <= 1'b1;
      r_write      <= 1'b0;
      r_byte       <= 8'h00;
      r_dir_valid  <= 1'b0;
      r_dir_out    <= 1'b0;
      r_settle_cnt <= 4'd0;
      r_rdata      <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            r_grant <= w_grant;
            r_last  <= w_grant;
            r_write <= w_sel_write;
            r_byte  <= w_sel_byte;
            r_state <= w_dir_hit ? S_XFER : S_DIR;
          end
        end
        S_DIR: begin
          r_dir_valid  <= 1'b1;
          r_dir_out    <= r_write;
          r_settle_cnt <= SETTLE_LOAD;
          r_state      <= HAS_SETTLE ? S_SETTLE : S_XFER;
        end
        S_SETTLE: begin
          if (r_settle_cnt == 4'd0) begin
            r_state <= S_XFER;
          end else begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
          end
        end
        S_XFER: begin
          r_state <= r_write ? S_ACK : S_CAPTURE;
        end
        S_CAPTURE: begin
          // PIO read data is registered, so it is valid one cycle after XFER.
          r_rdata <= bus.pio_readdata[7:0];
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_cs      = 1'b0;
    w_write_n = 1'b1;
    w_addr    = 3'd0;
    w_wdata   = 32'h0;
    case (r_state)
      S_DIR: begin
        w_cs      = 1'b1;
        w_write_n = 1'b0;
        w_addr    = 3'd1;
        w_wdata   = {24'h0, {8{r_write}}};
      end
      S_XFER: begin
        w_cs      = 1'b1;
        w_write_n = ~r_write;
        w_addr    = 3'd0;
        w_wdata   = r_write ? {24'h0, r_byte} : 32'h0;
      end
      default: begin
        w_cs = 1'b0;
      end
    endcase
  end

  assign bus.pio_chipselect = w_cs;
  assign bus.pio_write_n    = w_write_n;
  assign bus.pio_address    = w_addr;
  assign bus.pio_writedata  = w_wdata;
  assign bus.rdata          = r_rdata;
  assign bus.busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_soc_system_pio_sequencer.sv
// Scoreboard bench: stimulus pushes expected PIO accesses and acks, a negedge
// monitor pops and compares them for a SETTLE=2 and a SETTLE=0 instance.
module tb_soc_system_pio_sequencer;

  typedef struct {
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] data;
    int          cyc;
  } bus_t;

  typedef struct {
    int         req;
    logic [7:0] rd;
    int         cyc;
  } ack_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  logic [7:0] port_val = 8'h00;
  bit   chk_idle = 1'b1;
  bit   final_chk = 1'b0;
  int   tmo_cnt = 0;
  int   tmo_seen = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  bus_t exp_bus[2][$];
  ack_t exp_ack[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  soc_system_pio_sequencer_if ifa();
  soc_system_pio_sequencer_if ifb();

  soc_system_pio_sequencer #(.SETTLE_CYCLES(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa.slave)
  );

  soc_system_pio_sequencer #(.SETTLE_CYCLES(0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb.slave)
  );

  // PIO model: registered readdata, port value only returned for a data read.
  always @(posedge clk) begin
    ifa.pio_readdata <= (ifa.pio_chipselect && ifa.pio_write_n && ifa.pio_address == 3'd0)
                        ? {24'h0, port_val} : 32'h0;
    ifb.pio_readdata <= (ifb.pio_chipselect && ifb.pio_write_n && ifb.pio_address == 3'd0)
                        ? {24'h0, port_val} : 32'h0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic mon(input int d);
    logic        cs, wn, bsy;
    logic [2:0]  ad;
    logic [31:0] wd;
    logic [1:0]  ack;
    logic [7:0]  rd;
    bus_t        e;
    ack_t        a;
    if (d == 0) begin
      cs = ifa.pio_chipselect; wn = ifa.pio_write_n; ad = ifa.pio_address;
      wd = ifa.pio_writedata; ack = ifa.req_ack; rd = ifa.rdata; bsy = ifa.busy;
    end else begin
      cs = ifb.pio_chipselect; wn = ifb.pio_write_n; ad = ifb.pio_address;
      wd = ifb.pio_writedata; ack = ifb.req_ack; rd = ifb.rdata; bsy = ifb.busy;
    end
    if (chk_idle) begin
      chk($sformatf("dut%0d_rst_busy", d), 64'(bsy), 64'(0));
      chk($sformatf("dut%0d_rst_ack", d), 64'(ack), 64'(0));
      chk($sformatf("dut%0d_rst_rdata", d), 64'(rd), 64'(0));
      chk($sformatf("dut%0d_rst_bus", d), 64'({cs, wn, ad, wd}), 64'({1'b0, 1'b1, 3'd0, 32'h0}));
    end
    if (!reset_n) return;
    if (cs) begin
      chk($sformatf("dut%0d_bus_expected", d), 64'(exp_bus[d].size() != 0), 64'(1));
      if (exp_bus[d].size() != 0) begin
        e = exp_bus[d].pop_front();
        chk($sformatf("dut%0d_bus_access", d), 64'({wn, ad, wd}), 64'({e.wn, e.addr, e.data}));
        if (e.cyc >= 0) chk($sformatf("dut%0d_bus_cycle", d), 64'(cyc), 64'(e.cyc));
      end
    end
    if (ack != 2'b00) begin
      chk($sformatf("dut%0d_ack_expected", d), 64'(exp_ack[d].size() != 0), 64'(1));
      if (exp_ack[d].size() != 0) begin
        a = exp_ack[d].pop_front();
        $display("ack dut%0d req_ack=%b rdata=%02h cyc=%0d", d, ack, rd, cyc);
        chk($sformatf("dut%0d_ack_req", d), 64'(ack), 64'(2'b01 << a.req));
        chk($sformatf("dut%0d_ack_rdata", d), 64'(rd), 64'(a.rd));
        chk($sformatf("dut%0d_ack_busy", d), 64'(bsy), 64'(1));
        if (a.cyc >= 0) chk($sformatf("dut%0d_ack_cycle", d), 64'(cyc), 64'(a.cyc));
      end
    end
    if (final_chk) begin
      chk($sformatf("dut%0d_bus_q_drained", d), 64'(exp_bus[d].size()), 64'(0));
      chk($sformatf("dut%0d_ack_q_drained", d), 64'(exp_ack[d].size()), 64'(0));
    end
  endtask

  always @(negedge clk) begin
    if (tmo_cnt != tmo_seen) begin
      chk("ack_timeout_count", 64'(tmo_cnt), 64'(tmo_seen));
      tmo_seen = tmo_cnt;
    end
    mon(0);
    mon(1);
  end

  task automatic push_bus(input int d, input logic wn, input logic [2:0] ad,
                          input logic [31:0] dt, input int c);
    bus_t e;
    e.wn = wn; e.addr = ad; e.data = dt; e.cyc = c;
    exp_bus[d].push_back(e);
  endtask

  // lat < 0 means ordering-only checking (used under contention).
  task automatic push_op(input int d, input int r, input bit wr, input logic [7:0] data,
                         input bit dirchg, input int lat, input logic [7:0] exp_rd);
    ack_t a;
    int   c;
    c = cyc;
    if (dirchg) push_bus(d, 1'b0, 3'd1, wr ? 32'hFF : 32'h0, (lat < 0) ? -1 : c + 1);
    push_bus(d, ~wr, 3'd0, wr ? {24'h0, data} : 32'h0,
             (lat < 0) ? -1 : c + lat - (wr ? 1 : 2));
    a.req = r; a.rd = exp_rd; a.cyc = (lat < 0) ? -1 : c + lat;
    exp_ack[d].push_back(a);
  endtask

  function automatic logic ack_bit(input int d, input int r);
    return (d == 0) ? ifa.req_ack[r] : ifb.req_ack[r];
  endfunction

  task automatic hold_op(input int d, input int r, input bit wr, input logic [7:0] data);
    int n;
    if (d == 0) begin
      ifa.req_write[r] = wr; ifa.req_wdata[8*r +: 8] = data; ifa.req_valid[r] = 1'b1;
    end else begin
      ifb.req_write[r] = wr; ifb.req_wdata[8*r +: 8] = data; ifb.req_valid[r] = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_bit(d, r) && n < 40);
    if (!ack_bit(d, r)) begin
      $display("FAIL ack_wait: dut%0d req%0d got no ack, expected one within 40 cycles", d, r);
      tmo_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_req(input int d, input int r);
    if (d == 0) ifa.req_valid[r] = 1'b0;
    else        ifb.req_valid[r] = 1'b0;
  endtask

  task automatic do_op(input int d, input int r, input bit wr, input logic [7:0] data,
                       input bit dirchg, input int lat, input logic [7:0] exp_rd);
    push_op(d, r, wr, data, dirchg, lat, exp_rd);
    hold_op(d, r, wr, data);
    release_req(d, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no end, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.req_valid = 2'b00; ifa.req_write = 2'b00; ifa.req_wdata = 16'h0;
    ifb.req_valid = 2'b00; ifb.req_write = 2'b00; ifb.req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;

    // SETTLE=2: first write through DIR, cache-hit write, read with direction change.
    do_op(0, 0, 1'b1, 8'hA5, 1'b1, 5, 8'h00);
    do_op(0, 0, 1'b1, 8'h3C, 1'b0, 2, 8'h00);
    port_val = 8'h5A;
    do_op(0, 1, 1'b0, 8'h00, 1'b1, 6, 8'h5A);

    // Both requesters valid continuously, alternating ops: grants go 0,1,0,1.
    port_val = 8'h77;
    push_op(0, 0, 1'b1, 8'h11, 1'b1, -1, 8'h5A);
    push_op(0, 1, 1'b0, 8'h00, 1'b1, -1, 8'h77);
    push_op(0, 0, 1'b1, 8'h22, 1'b1, -1, 8'h77);
    push_op(0, 1, 1'b0, 8'h00, 1'b1, -1, 8'h77);
    fork
      begin
        hold_op(0, 0, 1'b1, 8'h11);
        hold_op(0, 0, 1'b1, 8'h22);
        release_req(0, 0);
      end
      begin
        hold_op(0, 1, 1'b0, 8'h00);
        hold_op(0, 1, 1'b0, 8'h00);
        release_req(0, 1);
      end
    join
    @(posedge clk);
    #1;

    // Write needing DIR, aborted by reset in the first SETTLE cycle.
    push_bus(0, 1'b0, 3'd1, 32'hFF, cyc + 1);
    ifa.req_write[0] = 1'b1; ifa.req_wdata[7:0] = 8'h99; ifa.req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    ifa.req_valid = 2'b00;
    chk_idle = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk_idle = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
    // Cache was invalidated, so the same direction is programmed again.
    do_op(0, 0, 1'b1, 8'h99, 1'b1, 5, 8'h00);

    // SETTLE=0 instance: write then read, DIR immediately followed by XFER.
    do_op(1, 0, 1'b1, 8'h42, 1'b1, 3, 8'h00);
    port_val = 8'hC3;
    do_op(1, 0, 1'b0, 8'h00, 1'b1, 4, 8'hC3);

    repeat (3) @(posedge clk);
    #1;
    final_chk = 1'b1;
    @(posedge clk);
    #1;
    final_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
